slave_port: RTL
===============

Name: slave_port

Overview:
- Serial slave endpoint fed directly by the master mux's per-slave output bundle (one instance per slave: 1, 2, 3).
- Deserialises the address and write data, and performs single or burst accesses on a local word memory.
- Serialises read data back towards the master side.
- All bus data lines are 1 bit wide, sent LSB first.

Parameters:
ADDR_WIDTH, 12, serial address length in bits
DATA_WIDTH, 8, word width in bits
MEM_DEPTH, 4096, number of words; must be at most 2**ADDR_WIDTH

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
master_ready  input  1  master accepts the current rx_data bit
master_valid  input  1  master drives a valid command/address/data bit this cycle
read_en  input  1  read command qualifier
write_en  input  1  write command qualifier
tx_address  input  1  serial address bit
tx_data  input  1  serial write-data bit
tx_burst  input  1  continue with the next sequential word
tx_done  input  1  master abort/terminate
slave_ready  output  1  slave can accept a bit
slave_valid  output  1  rx_data holds a valid read bit
rx_data  output  1  serial read-data bit
slave_err  output  1  one-cycle error pulse

Behaviour:
- Clock/reset (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values: slave_ready=0 in the reset cycle and 1 afterwards (IDLE); slave_valid=0; rx_data=0; slave_err=0; FSM=IDLE; all counters 0.
- Reset mid-operation: transfer dropped, no memory write, memory contents preserved.
- A bit is consumed only on cycles with master_valid=1 (inputs) or master_ready=1 (read output); other cycles stall with state held.
- IDLE:
  - start = master_valid & (read_en ^ write_en); tx_address is captured as addr bit 0 on that cycle; go to ADDR.
  - master_valid with read_en & write_en both set: slave_err pulse, stay in IDLE.
- ADDR: capture bits 1..ADDR_WIDTH-1. After the last bit, go to WDATA (write) or RLOAD (read).
- Out-of-range address (addr >= MEM_DEPTH):
  - slave_err pulse on the cycle after the last address bit.
  - Write: data is still shifted in but discarded.
  - Read: returns all zeros.
- WDATA:
  - Shift DATA_WIDTH bits of tx_data.
  - On the last bit's edge, mem[addr] is written; readable from the next cycle.
  - If tx_burst=1 on the last bit: addr = addr+1, wrapping to 0 at MEM_DEPTH; stay in WDATA.
  - Otherwise go to IDLE.
- RLOAD: one cycle; registered memory read into the shift register; slave_ready=0.
- RDATA:
  - slave_valid=1, rx_data = current bit.
  - Advance on master_ready=1.
  - After the last bit: if tx_burst=1 (sampled at that handshake), increment addr with wrap and go to RLOAD; else slave_valid=0 and go to IDLE.
- tx_done=1 with master_valid in ADDR/WDATA, or tx_done=1 with master_ready in RDATA:
  - Go to IDLE next cycle; no partial write; no slave_err.
  - tx_done has priority over tx_burst.
- slave_ready: 1 in IDLE/ADDR/WDATA, 0 in RLOAD/RDATA.
- Latency at default parameters with no stalls:
  - Write: 12 address + 8 data cycles.
  - Read: 12 address cycles, 1 RLOAD, first data bit in the next cycle.

Optional Feature:
- Macro SLAVE_PARITY_EN.
- Defined:
  - WDATA takes DATA_WIDTH+1 bits; the final bit is even parity over the word.
  - On mismatch: write suppressed, slave_err pulses, burst continues to the next address.
  - RDATA appends a parity bit after the data bits.
- Undefined: no parity bits; logic absent.

Decomposition:
- Package system_bus_pkg:
  - FSM state enum (IDLE, ADDR, WDATA, RLOAD, RDATA).
  - Grant encoding constants shared with the mux (bus grant M1=2'b01, M2=2'b10; slave grant S1=3'b011, S2=3'b101, S3=3'b111).
  - Default widths.
- Sub-module slave_mem:
  - Single-port synchronous RAM, MEM_DEPTH x DATA_WIDTH, registered read.
- The FSM and shift registers stay in slave_port.

Test Plan:
- Single write then read (defaults): write addr 0x005 with 0xA5, then read addr 0x005 -> rx_data bits 1,0,1,0,0,1,0,1 over 8 master_ready cycles; slave_err=0.
- Burst write wrap: start at addr 0xFFF, write 0x11 then 0x22 with tx_burst=1 on the first word's last bit -> mem[0xFFF]=0x11, mem[0x000]=0x22.
- Stalls: master_valid toggling every other cycle during a write of 0x3C, and master_ready held low for 5 cycles mid-read -> data intact, rx_data held while stalled.
- Abort: tx_done=1 at data bit 4 of a write to 0x010 -> mem[0x010] unchanged, IDLE next cycle; read_en & write_en both set in IDLE -> slave_err pulse.
- Reset mid-read at bit 3: rst high one cycle -> slave_valid=0 and slave_ready=1 after reset, memory retained; a new read of the same address returns the original word.
- SLAVE_PARITY_EN defined: write 0x07 with parity bit 0 -> write suppressed and slave_err pulses; same write with parity bit 1 -> stored.

Source files
------------

// File: rtl/system_bus_pkg.sv
// Shared bus definitions: slave FSM states, grant encodings used by the master mux,
// and default slave geometry.
package system_bus_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWdata,
    StRload,
    StRdata
  } slave_state_e;

  localparam logic [1:0] BusGrantM1   = 2'b01;
  localparam logic [1:0] BusGrantM2   = 2'b10;
  localparam logic [2:0] SlaveGrantS1 = 3'b011;
  localparam logic [2:0] SlaveGrantS2 = 3'b101;
  localparam logic [2:0] SlaveGrantS3 = 3'b111;

  localparam int unsigned DefAddrWidth = 12;
  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefMemDepth  = 4096;

  function automatic int unsigned max_bits(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/slave_mem.sv
// Single-port synchronous word RAM with registered read; out-of-range reads return zero.
module slave_mem #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 4096
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    o_rdata <= (32'(i_addr) < MEM_DEPTH) ? r_mem[i_addr] : '0;
  end

endmodule

// File: rtl/slave_port.sv
// Serial slave endpoint: deserialises address/write data, accesses slave_mem, serialises reads.
// Optional SLAVE_PARITY_EN adds an even-parity bit after each write and read word.
module slave_port
  import system_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned MEM_DEPTH  = DefMemDepth
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_master_ready,
  input  logic i_master_valid,
  input  logic i_read_en,
  input  logic i_write_en,
  input  logic i_tx_address,
  input  logic i_tx_data,
  input  logic i_tx_burst,
  input  logic i_tx_done,
  output logic o_slave_ready,
  output logic o_slave_valid,
  output logic o_rx_data,
  output logic o_slave_err
);

`ifdef SLAVE_PARITY_EN
  localparam int unsigned WordBits = DATA_WIDTH + 1;
`else
  localparam int unsigned WordBits = DATA_WIDTH;
`endif
  localparam int unsigned    CntW        = $clog2(max_bits(ADDR_WIDTH, WordBits) + 1);
  localparam logic [CntW-1:0] CntAddrLast = CntW'(ADDR_WIDTH - 1);
  localparam logic [CntW-1:0] CntWordLast = CntW'(WordBits - 1);

  slave_state_e          r_state, w_state_d;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_d, w_addr_inc, w_mem_addr;
  logic [CntW-1:0]       r_cnt, w_cnt_d;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_d, w_wdata, w_mem_rdata;
  logic                  r_write, w_write_d;
  logic                  r_oor, w_oor_d;
  logic                  r_err, w_err_d;
  logic                  w_mem_we, w_tx_bit;

`ifdef SLAVE_PARITY_EN
  localparam logic [CntW-1:0] CntParity = CntW'(DATA_WIDTH);
  logic r_rpar, w_rpar_d;
  // The parity bit is not shifted in, so the full word already sits in r_shift.
  assign w_wdata  = r_shift;
  assign w_tx_bit = (r_cnt == CntParity) ? r_rpar : r_shift[0];
`else
  assign w_wdata  = {i_tx_data, r_shift[DATA_WIDTH-1:1]};
  assign w_tx_bit = r_shift[0];
`endif

  assign w_addr_inc = (32'(r_addr) + 32'd1 >= MEM_DEPTH) ? '0 : r_addr + 1'b1;
  // The RAM samples the next address so a read word is ready during StRload.
  assign w_mem_addr = w_mem_we ? r_addr : w_addr_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_addr_d  = r_addr;
    w_cnt_d   = r_cnt;
    w_shift_d = r_shift;
    w_write_d = r_write;
    w_oor_d   = r_oor;
    w_err_d   = 1'b0;
    w_mem_we  = 1'b0;
`ifdef SLAVE_PARITY_EN
    w_rpar_d  = r_rpar;
`endif
    unique case (r_state)
      StIdle: begin
        if (i_master_valid && (i_read_en ^ i_write_en)) begin
          w_state_d = StAddr;
          w_addr_d  = {i_tx_address, r_addr[ADDR_WIDTH-1:1]};
          w_cnt_d   = CntW'(1);
          w_write_d = i_write_en;
        end else if (i_master_valid && i_read_en && i_write_en) begin
          w_err_d = 1'b1;
        end
      end
      StAddr: begin
        if (i_master_valid && i_tx_done) begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end else if (i_master_valid) begin
          w_addr_d = {i_tx_address, r_addr[ADDR_WIDTH-1:1]};
          if (r_cnt == CntAddrLast) begin
            w_cnt_d   = '0;
            w_oor_d   = (32'(w_addr_d) >= MEM_DEPTH);
            w_err_d   = w_oor_d;
            w_state_d = r_write ? StWdata : StRload;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
      end
      StWdata: begin
        if (i_master_valid && i_tx_done) begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end else if (i_master_valid) begin
`ifdef SLAVE_PARITY_EN
          if (r_cnt == CntWordLast) begin
            if (^{r_shift, i_tx_data}) begin
              w_err_d = 1'b1;
            end else begin
              w_mem_we = ~r_oor & ~i_rst;
            end
          end else begin
            w_shift_d = {i_tx_data, r_shift[DATA_WIDTH-1:1]};
          end
`else
          w_shift_d = {i_tx_data, r_shift[DATA_WIDTH-1:1]};
          w_mem_we  = (r_cnt == CntWordLast) & ~r_oor & ~i_rst;
`endif
          if (r_cnt == CntWordLast) begin
            w_cnt_d = '0;
            if (i_tx_burst) begin
              w_addr_d = w_addr_inc;
              w_oor_d  = 1'b0;
            end else begin
              w_state_d = StIdle;
            end
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
      end
      StRload: begin
        w_shift_d = r_oor ? '0 : w_mem_rdata;
        w_cnt_d   = '0;
        w_state_d = StRdata;
`ifdef SLAVE_PARITY_EN
        w_rpar_d  = ^w_shift_d;
`endif
      end
      StRdata: begin
        if (i_master_ready && i_tx_done) begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end else if (i_master_ready) begin
          w_shift_d = r_shift >> 1;
          if (r_cnt == CntWordLast) begin
            w_cnt_d = '0;
            if (i_tx_burst) begin
              w_addr_d  = w_addr_inc;
              w_oor_d   = 1'b0;
              w_state_d = StRload;
            end else begin
              w_state_d = StIdle;
            end
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr  <= '0;
      r_cnt   <= '0;
      r_shift <= '0;
      r_write <= 1'b0;
      r_oor   <= 1'b0;
      r_err   <= 1'b0;
`ifdef SLAVE_PARITY_EN
      r_rpar  <= 1'b0;
`endif
    end else begin
      r_addr  <= w_addr_d;
      r_cnt   <= w_cnt_d;
      r_shift <= w_shift_d;
      r_write <= w_write_d;
      r_oor   <= w_oor_d;
      r_err   <= w_err_d;
`ifdef SLAVE_PARITY_EN
      r_rpar  <= w_rpar_d;
`endif
    end
  end

  always_comb begin
    o_slave_ready = 1'b0;
    o_slave_valid = 1'b0;
    o_rx_data     = 1'b0;
    o_slave_err   = r_err;
    if (!i_rst) begin
      o_slave_ready = (r_state == StIdle) || (r_state == StAddr) || (r_state == StWdata);
      if (r_state == StRdata) begin
        o_slave_valid = 1'b1;
        o_rx_data     = w_tx_bit;
      end
    end
  end

  slave_mem #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_mem (
    .i_clk  (i_clk),
    .i_we   (w_mem_we),
    .i_addr (w_mem_addr),
    .i_wdata(w_wdata),
    .o_rdata(w_mem_rdata)
  );

endmodule
